// File: rtl/cmds_scan_sched_pkg.sv
// Shared definitions for the cmds_scan round scheduler: address width, slot stride,
// one-hot state encodings and the slot base-address helper.
package cmds_scan_sched_pkg;

    localparam int ADDR_W         = 12;
    localparam int SLOT_BYTES_DEF = 8;

    // One-hot encodings, also used by cmds_scan when it decodes scheduler state
    typedef enum logic [7:0] {
        ST_IDLE  = 8'h01,
        ST_CHECK = 8'h02,
        ST_WAIT  = 8'h04,
        ST_NEXT  = 8'h08,
        ST_FIN   = 8'h10
    } sched_state_t;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                    input int unsigned      idx,
                                                    input int unsigned      stride);
        logic [31:0] full;
        full = 32'(base) + idx * stride;
        return full[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/cmds_scan_sched.sv
// Round scheduler feeding cmds_scan: walks the latched slot mask, one start/done per slot.
// Optional done-timeout logic is built when CMDS_SCHED_TMO_EN is defined.
module cmds_scan_sched
    import cmds_scan_sched_pkg::*;
#(
    parameter int unsigned        SLOT_NUM   = 16,
    parameter int unsigned        SLOT_BYTES = SLOT_BYTES_DEF,
    parameter logic [ADDR_W-1:0]  BASE_START = 12'd0,
    parameter logic [15:0]        DONE_TMO   = 16'd3000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cycle_start,
    input  logic [SLOT_NUM-1:0] im_slot_mask,
    output logic                o_start_scan,
    output logic [ADDR_W-1:0]   om_base_addr,
    input  logic                i_done_scan,
    output logic                o_busy,
    output logic                o_round_done,
    output logic                o_overrun,
    output logic                o_tmo_err,
    output logic [7:0]          om_tmo_cnt
);

    localparam int IDX_W = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_NUM - 1);

    sched_state_t        state, state_nx;
    logic [SLOT_NUM-1:0] mask_q;
    logic [IDX_W-1:0]    slot_idx;
    logic                tmo_hit;

    logic                start_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic                busy_nx;
    logic                round_done_nx;
    logic                overrun_nx;

`ifdef CMDS_SCHED_TMO_EN
    logic [15:0] wait_cnt;

    // A done arriving in the timeout cycle takes priority, so no error is raised
    assign tmo_hit = (state == ST_WAIT) && !i_done_scan && (wait_cnt == DONE_TMO - 16'd1);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mask_q       <= '0;
            slot_idx     <= '0;
            o_start_scan <= 1'b0;
            om_base_addr <= '0;
            o_busy       <= 1'b0;
            o_round_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= state_nx;
            o_start_scan <= start_nx;
            om_base_addr <= addr_nx;
            o_busy       <= busy_nx;
            o_round_done <= round_done_nx;
            o_overrun    <= overrun_nx;
            if (state == ST_IDLE && i_cycle_start) begin
                mask_q   <= im_slot_mask;
                slot_idx <= '0;
            end else if (state == ST_NEXT && slot_idx != LAST_IDX) begin
                slot_idx <= slot_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE:  state_nx = i_cycle_start ? ST_CHECK : ST_IDLE;
            ST_CHECK: state_nx = mask_q[slot_idx] ? ST_WAIT : ST_NEXT;
            ST_WAIT:  state_nx = (i_done_scan || tmo_hit) ? ST_NEXT : ST_WAIT;
            ST_NEXT:  state_nx = (slot_idx == LAST_IDX) ? ST_FIN : ST_CHECK;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        start_nx      = (state == ST_CHECK) && mask_q[slot_idx];
        addr_nx       = start_nx ? slot_addr(BASE_START, 32'(slot_idx), SLOT_BYTES) : om_base_addr;
        round_done_nx = (state == ST_FIN);
        overrun_nx    = i_cycle_start && (state != ST_IDLE);
        busy_nx       = 1'b0;
        case (state)
            ST_IDLE:                   busy_nx = i_cycle_start;
            ST_CHECK, ST_WAIT, ST_NEXT: busy_nx = 1'b1;
            default:                   busy_nx = 1'b0;
        endcase
    end

`ifdef CMDS_SCHED_TMO_EN
    // Counts WAIT cycles for the current slot; the error count is cumulative until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            o_tmo_err  <= 1'b0;
            om_tmo_cnt <= '0;
        end else begin
            if (state == ST_CHECK)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 16'd1;
            o_tmo_err <= tmo_hit;
            if (tmo_hit && om_tmo_cnt != 8'hFF)
                om_tmo_cnt <= om_tmo_cnt + 8'd1;
        end
    end
`else
    assign o_tmo_err  = 1'b0;
    assign om_tmo_cnt = 8'd0;
`endif

endmodule
